rf_dump_reader: RTL and testbench
=================================

// Module: rf_dump_reader
// PURPOSE
//  Read-side sweep engine for Reg_File: on Start, reads every register through both RF read
//  ports, two registers per fetch, and streams (address, data) beats on a valid/ready output.
//  Sits between Reg_File's RAddr1/RAddr2/RData1/RData2 and a debug/trace consumer.
//  It is the complement of the RF write path and is used for state dumps and RF self-check.
// PARAMETERS
//  RSIZE  4   register address width; 2^RSIZE registers, always even
//  DSIZE  16  register data width
// PORTS
//  Clock     in   1      system clock, rising edge
//  Reset     in   1      synchronous, active-high reset
//  Start     in   1      request a full sweep; sampled only in IDLE
//  RAddr1    out  RSIZE  RF read address port 1 = {pair,1'b0}
//  RAddr2    out  RSIZE  RF read address port 2 = {pair,1'b1}
//  RData1    in   DSIZE  RF read data 1, combinational from RAddr1
//  RData2    in   DSIZE  RF read data 2, combinational from RAddr2
//  OutValid  out  1      output beat valid
//  OutReady  in   1      consumer accepts beat when OutValid&&OutReady at clock edge
//  OutAddr   out  RSIZE  register index of current beat
//  OutData   out  DSIZE  register contents of current beat
//  Busy      out  1      high in any state other than IDLE
//  Done      out  1      one-cycle pulse after final beat accepted
// BEHAVIOUR
//  - One clock; Reset synchronous active-high, overrides everything incl. mid-sweep.
//  - Reset values: state=IDLE, pair=0 (RAddr1=0, RAddr2=1), OutValid=0, OutAddr=0,
//    OutData=0, Busy=0, Done=0, capture buffer cleared to 0.
//  - pair counter is RSIZE-1 bits; last pair when pair is all ones.
//  - FSM: IDLE, FETCH, EMIT0, EMIT1, DONE.
//    IDLE : pair held at 0; Start=1 -> FETCH. Start=0 -> stay.
//    FETCH: RAddr1/RAddr2 driven from pair; RData1/RData2 captured into buf0/buf1 at edge -> EMIT0.
//    EMIT0: OutValid=1, OutAddr={pair,0}, OutData=buf0; on OutReady -> EMIT1, else hold.
//    EMIT1: OutValid=1, OutAddr={pair,1}, OutData=buf1; on OutReady: if last pair -> DONE,
//           else pair+1 -> FETCH; else hold.
//    DONE : Done=1 for exactly this cycle, pair cleared to 0 -> IDLE.
//  - Outputs OutValid/OutAddr/OutData/Busy/Done are registered (no comb path from OutReady).
//  - Hold rule: while OutValid=1 and OutReady=0, OutAddr/OutData remain stable.
//  - Snapshot rule: data emitted is the value captured in FETCH; RF writes to the same pair
//    after FETCH do not alter the in-flight beats.
//  - Start while Busy is ignored (no queuing); Start in DONE cycle is ignored.
//  - Min latency: Start sampled at edge N -> FETCH in N+1, first beat valid in N+2.
//    Full sweep at OutReady=1: 3 cycles/pair, Done high at N+1+3*2^(RSIZE-1).
//  - No wrap-around: pair never increments past last pair; one Start = exactly 2^RSIZE beats.
//  - Reset mid-sweep: next cycle IDLE, OutValid=0, no Done pulse, partial beats discarded.
// TESTING
//  1 RF preloaded reg i = i+16; Start 1 cycle, OutReady=1 -> 16 beats, OutAddr 0..F,
//    OutData 0x0010..0x001F in order; Done single pulse 25 cycles after Start edge.
//  2 Same preload, OutReady toggled 1,0,0,1,... -> same 16 beats, no loss/duplication,
//    OutAddr/OutData stable during every stall; Done only after beat F accepted.
//  3 Start held high for 40 cycles -> two back-to-back sweeps of 16 beats each,
//    no Start captured while Busy; Busy=0 only in IDLE cycles between sweeps.
//  4 During EMIT0 of pair 2, write reg 4 := 0x0005 via RF write port -> beat 4 still
//    0x0014; a later sweep reports 0x0005 for reg 4.
//  5 Reset asserted during EMIT1 of pair 3 -> next cycle OutValid=0, Busy=0, Done=0,
//    RAddr1=0, RAddr2=1; new Start gives full sweep beginning at addr 0.
//  6 Start with OutReady=0 for 10 cycles -> OutValid=1, OutAddr=0, OutData=0x0010 held
//    throughout; no Done; Busy=1.

Source files
------------

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: sweeps every register of a two-read-port register file.
// One fetch reads an even/odd register pair. The pair is snapshotted and then
// streamed as two (address, data) beats on a registered valid/ready output.
module rf_dump_reader #(
  parameter int RSIZE = 4,
  parameter int DSIZE = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic [RSIZE-1:0] raddr1_o,
  output logic [RSIZE-1:0] raddr2_o,
  input  logic [DSIZE-1:0] rdata1_i,
  input  logic [DSIZE-1:0] rdata2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RSIZE-1:0] out_addr_o,
  output logic [DSIZE-1:0] out_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int PW = RSIZE - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EMIT0 = 3'd2,
    S_EMIT1 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pair_q, pair_d;
  logic [DSIZE-1:0] buf0_q, buf1_q;
  logic             out_valid_q, out_valid_d;
  logic [RSIZE-1:0] out_addr_q, out_addr_d;
  logic [DSIZE-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_pair;

  assign last_pair = &pair_q;

  // Both read ports always point at the current pair.
  assign raddr1_o = {pair_q, 1'b0};
  assign raddr2_o = {pair_q, 1'b1};

  // State register.
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and pair-counter logic; the pair never wraps past the last one.
  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    case (state_q)
      S_IDLE: begin
        pair_d = '0;
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_EMIT0;
      S_EMIT0: if (out_ready_i) state_d = S_EMIT1;
      S_EMIT1: begin
        if (out_ready_i) begin
          if (last_pair) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            pair_d  = pair_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        pair_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        pair_d  = '0;
      end
    endcase
  end

  // Output next-values, derived from the upcoming state so the outputs can be registered.
  // Beat payload is loaded only on entry to an emit state, so it holds during stalls.
  always_comb begin
    out_valid_d = (state_d == S_EMIT0) || (state_d == S_EMIT1);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (state_d == S_EMIT0 && state_q == S_FETCH) begin
      out_addr_d = {pair_q, 1'b0};
      out_data_d = rdata1_i;
    end else if (state_d == S_EMIT1 && state_q == S_EMIT0) begin
      out_addr_d = {pair_q, 1'b1};
      out_data_d = buf1_q;
    end
  end

  // Datapath registers: pair counter, pair snapshot and registered outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pair_q      <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pair_q <= pair_d;
      if (state_q == S_FETCH) begin
        buf0_q <= rdata1_i;
        buf1_q <= rdata2_i;
      end
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: a small register file model feeds the read ports,
// expected beats are queued by the stimulus and checked by a negedge monitor.
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  raddr1, raddr2, out_addr;
  logic [15:0] rdata1, rdata2, out_data;
  logic        out_valid, busy, done;

  logic [15:0] rf [16];
  logic [19:0] sb [$];

  int vec_cnt = 0;
  int miss_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_cyc = 0;
  bit first_seen = 0;
  int start_edge = 0;
  int last_addr = -1;
  bit prev_stall = 0;
  logic [3:0]  prev_addr = '0;
  logic [15:0] prev_data = '0;
  int exp_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];

  rf_dump_reader #(.RSIZE(4), .DSIZE(16)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start),
    .raddr1_o(raddr1), .raddr2_o(raddr2),
    .rdata1_i(rdata1), .rdata2_i(rdata2),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_data_o(out_data),
    .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one full sweep: reg i = i+16, except reg 4 which is given explicitly.
  task automatic push_sweep(input logic [15:0] r4);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      v = (i == 4) ? r4 : 16'(i + 16);
      sb.push_back({4'(i), v});
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    first_seen = 0;
    tick();
    start_edge = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_done_count"}, done_cnt, exp_done);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: pops expected beats on every accepted beat and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && out_valid) begin
        chk("hold_addr", out_addr, prev_addr);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && !first_seen) begin
        first_seen = 1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h expected none", out_addr, out_data);
        end else begin
          logic [19:0] e;
          e = sb.pop_front();
          chk("beat_addr", out_addr, e[19:16]);
          chk("beat_data", out_data, e[15:0]);
          $display("beat addr=%0h data=%04h", out_addr, out_data);
        end
        last_addr = int'(out_addr);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_last", last_addr, 15);
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int idle_cnt;
    int done_before;

    for (int i = 0; i < 16; i++) rf[i] = 16'(i + 16);

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr1", raddr1, 0);
    chk("rst_raddr2", raddr2, 1);
    rst = 1'b0;
    tick();

    // 1: full sweep, always ready, latency check
    out_ready = 1'b1;
    push_sweep(16'h0014);
    start_pulse();
    wait_done("t1", 80);
    chk("t1_first_lat", first_cyc - start_edge, 1);
    chk("t1_done_lat", done_cyc - start_edge, 24);
    repeat (3) tick();
    chk("t1_single_done", done_cnt, exp_done);
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: ready toggled 1,0,0,1,0,0,...
    push_sweep(16'h0014);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_done++;
    for (int k = 0; k < 200 && done_cnt < exp_done; k++) begin
      out_ready = (k % 3 == 0);
      tick();
    end
    chk("t2_done_count", done_cnt, exp_done);
    chk("t2_sb_empty", sb.size(), 0);
    out_ready = 1'b1;
    repeat (2) tick();

    // 3: Start held for 40 cycles -> two back-to-back sweeps
    push_sweep(16'h0014);
    push_sweep(16'h0014);
    start = 1'b1;
    idle_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!busy) idle_cnt++;
    end
    start = 1'b0;
    chk("t3_idle_between", idle_cnt, 1);
    exp_done++;
    wait_done("t3", 80);
    repeat (3) tick();
    chk("t3_no_third", busy, 0);

    // 4: write reg 4 while its beat is in flight
    push_sweep(16'h0014);
    start_pulse();
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (out_valid && out_addr == 4'd4) begin
        rf[4] = 16'h0005;
        found = 1;
      end else begin
        tick();
      end
    end
    chk("t4_reach_beat4", found, 1);
    wait_done("t4a", 80);
    tick();
    push_sweep(16'h0005);
    start_pulse();
    wait_done("t4b", 80);
    tick();

    // 5: reset during EMIT1 of pair 3
    push_sweep(16'h0005);
    start_pulse();
    done_before = done_cnt;
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (out_valid && out_addr == 4'd7) found = 1;
      else tick();
    end
    chk("t5_reach_beat7", found, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_raddr1", raddr1, 0);
    chk("t5_raddr2", raddr2, 1);
    repeat (2) tick();
    chk("t5_no_done_pulse", done_cnt, done_before);
    out_ready = 1'b1;
    push_sweep(16'h0005);
    start_pulse();
    wait_done("t5", 80);
    tick();

    // 6: stalled consumer for 10 cycles at the first beat
    out_ready = 1'b0;
    push_sweep(16'h0005);
    start_pulse();
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("t6_valid", out_valid, 1);
      chk("t6_addr", out_addr, 0);
      chk("t6_data", out_data, 16'h0010);
      chk("t6_done", done, 0);
      chk("t6_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    wait_done("t6", 80);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
